// File: rtl/fft_power_reorder.sv
// fft_power_reorder
//   Turns a bit-reversed FFT output stream into a natural-order power spectrum.
//   For each accepted sample it computes Re^2+Im^2 exactly and keeps only the
//   non-negative-frequency bins 0..N_FFT/2. Two ping-pong banks let the next
//   frame be written while the previous one is read out. A frame that arrives
//   while its target bank is still unread is discarded whole.
//
// Ports
//   clk                    : single clock, rising edge
//   rst                    : synchronous active-high reset (highest priority)
//   spi_en_inf_system_sync : enable; low clears all control state and ignores valid_in
//   valid_in, Re_in, Im_in : one signed FFT sample per cycle when valid_in=1
//   out_valid, out_ready   : ready/valid handshake on the output side
//   out_bin                : natural-order bin index 0..N_FFT/2
//   out_pwr                : unsigned power of out_bin
//   out_last               : out_bin is N_FFT/2 (final bin of the frame)
//   frame_drop             : one-cycle pulse when an input frame is discarded
module fft_power_reorder #(
  parameter int N_FFT     = 256,
  parameter int IN_WIDTH  = 15,
  parameter int PWR_WIDTH = 2*IN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spi_en_inf_system_sync,
  input  logic                       valid_in,
  input  logic signed [IN_WIDTH-1:0] Re_in,
  input  logic signed [IN_WIDTH-1:0] Im_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_FFT)-1:0]   out_bin,
  output logic [PWR_WIDTH-1:0]       out_pwr,
  output logic                       out_last,
  output logic                       frame_drop
);

  localparam int LOG2 = $clog2(N_FFT);
  localparam int N_BINS = N_FFT/2 + 1;
  localparam logic [LOG2-1:0] LAST_BIN = LOG2'(N_FFT/2);
  localparam logic [LOG2-1:0] K_LAST   = LOG2'(N_FFT-1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} rd_state_t;

  // Each square of a signed IN_WIDTH value is non-negative and fits in
  // 2*IN_WIDTH-1 bits, so summing them as unsigned is exact.
  function automatic logic [PWR_WIDTH-1:0] cplx_pwr(
    input logic signed [IN_WIDTH-1:0] re,
    input logic signed [IN_WIDTH-1:0] im
  );
    logic signed [2*IN_WIDTH-1:0] re_sq;
    logic signed [2*IN_WIDTH-1:0] im_sq;
    re_sq = re * re;
    im_sq = im * im;
    return PWR_WIDTH'(unsigned'(re_sq)) + PWR_WIDTH'(unsigned'(im_sq));
  endfunction

  function automatic logic [LOG2-1:0] bitrev(input logic [LOG2-1:0] v);
    logic [LOG2-1:0] r;
    for (int i = 0; i < LOG2; i++) r[i] = v[LOG2-1-i];
    return r;
  endfunction

  logic                 clr;
  logic                 accept;
  logic [LOG2-1:0]      k_p0;
  logic [LOG2-1:0]      bin_p0;
  logic                 last_p0;
  logic                 cur_drop;
  logic                 wr_en_p0;
  logic                 wr_bank;
  logic                 drop_frame;
  logic [1:0]           full;

  logic                 vld_p1;
  logic                 done_p1;
  logic                 bank_p1;
  logic [LOG2-1:0]      addr_p1;
  logic [PWR_WIDTH-1:0] pwr_p1;
  logic                 vld_p2;
  logic                 bank_p2;

  logic [PWR_WIDTH-1:0] mem [2][N_BINS];

  rd_state_t            state_q;
  rd_state_t            state_d;
  logic                 rd_bank;
  logic [LOG2-1:0]      rd_bin;
  logic                 xfer;
  logic                 rd_done;

  assign clr     = rst | ~spi_en_inf_system_sync;
  assign accept  = valid_in & spi_en_inf_system_sync;
  assign bin_p0  = bitrev(k_p0);
  assign last_p0 = (k_p0 == K_LAST);
  // The keep/drop decision for a frame is made at its first sample and
  // latched for the remaining samples.
  assign cur_drop = (k_p0 == '0) ? full[wr_bank] : drop_frame;
  assign wr_en_p0 = accept & ~cur_drop & (bin_p0 <= LAST_BIN);

  // ---- p0: sample acceptance, write-side control ----
  // The write bank toggles at the last sample so the next frame's first
  // sample, possibly on the very next cycle, checks the other bank.
  always_ff @(posedge clk) begin
    if (clr) begin
      k_p0       <= '0;
      wr_bank    <= 1'b0;
      drop_frame <= 1'b0;
      frame_drop <= 1'b0;
      vld_p1     <= 1'b0;
      done_p1    <= 1'b0;
      vld_p2     <= 1'b0;
    end else begin
      frame_drop <= accept & (k_p0 == '0) & full[wr_bank];
      vld_p1     <= wr_en_p0;
      done_p1    <= accept & last_p0 & ~cur_drop;
      vld_p2     <= done_p1;
      if (accept) begin
        k_p0 <= k_p0 + LOG2'(1);
        if (k_p0 == '0) drop_frame <= full[wr_bank];
        if (last_p0 && !cur_drop) wr_bank <= ~wr_bank;
      end
    end
  end

  // ---- p1: registered power, bank write ----
  always_ff @(posedge clk) begin
    pwr_p1  <= cplx_pwr(Re_in, Im_in);
    addr_p1 <= bin_p0;
    bank_p1 <= wr_bank;
    bank_p2 <= bank_p1;
    if (vld_p1) mem[bank_p1][addr_p1] <= pwr_p1;
  end

  // ---- p2: full flags (write side sets, read side clears) ----
  always_ff @(posedge clk) begin
    if (clr) begin
      full <= 2'b00;
    end else begin
      if (vld_p2) full[bank_p2] <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  // ---- read side ----
  assign xfer    = out_valid & out_ready;
  assign rd_done = xfer & out_last;

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (full[rd_bank]) state_d = SEND;
      SEND: if (rd_done && !full[~rd_bank]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_bin  <= '0;
      rd_bank <= 1'b0;
    end else if (xfer) begin
      if (out_last) begin
        rd_bin  <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_bin <= rd_bin + LOG2'(1);
      end
    end
  end

  // A full bank is never written, so the read port is stable during stalls.
  always_comb begin
    out_valid = (state_q == SEND);
    out_bin   = rd_bin;
    out_last  = (state_q == SEND) && (rd_bin == LAST_BIN);
    out_pwr   = '0;
    if (state_q == SEND) out_pwr = mem[rd_bank][rd_bin];
  end

endmodule

// File: tb/tb_fft_power_reorder.sv
// Bench for fft_power_reorder: table vectors, directed multi-cycle sequences
// and randomized frames checked against a frame-level scoreboard.
module tb_fft_power_reorder;

  logic               clk = 1'b0;
  logic               rst;
  logic               spi_en;
  logic               valid_in;
  logic signed [14:0] Re_in;
  logic signed [14:0] Im_in;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_bin;
  logic [29:0]        out_pwr;
  logic               out_last;
  logic               frame_drop;

  fft_power_reorder #(.N_FFT(256), .IN_WIDTH(15), .PWR_WIDTH(30)) dut (
    .clk(clk), .rst(rst), .spi_en_inf_system_sync(spi_en),
    .valid_in(valid_in), .Re_in(Re_in), .Im_in(Im_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_pwr(out_pwr), .out_last(out_last), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bin;
    logic [29:0] pwr;
    logic        last;
  } exp_t;

  typedef struct {
    int bin;
    int re;
    int im;
    int exp_pwr;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          call_no  = 0;
  int          fre [256];
  int          fim [256];
  int          buf_m [256];
  int          k_m = 0;
  bit          mdrop = 0;
  int          outstanding = 0;
  bit          exp_drop = 0;
  exp_t        exp_q [$];
  logic [29:0] got_pwr [129];
  int          xfer_cnt = 0;
  int          drop_seen = 0;
  int          drop_call = -1;
  int          rise_call = -1;
  int          k0_call = 0;
  int          last_call = 0;
  logic        prev_valid = 1'b0;
  bit          hold_v = 0;
  logic [39:0] held;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
  endfunction

  function automatic int bitrev8(int v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r |= (1 << (7 - i));
    return r;
  endfunction

  function automatic logic get_rdy(int mode);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return call_no[0];
      3: return $urandom_range(0, 3) != 0;
      default: return $urandom_range(0, 3) == 0;
    endcase
  endfunction

  function automatic void model_clear();
    k_m = 0;
    mdrop = 0;
    outstanding = 0;
    exp_q.delete();
    exp_drop = 0;
    hold_v = 0;
  endfunction

  // Frame-level reference: collect a frame by arrival index, then emit its
  // non-negative bins in natural order. A new frame is refused when two
  // completed frames are still waiting to be fully read.
  function automatic void accept_model(int re, int im);
    exp_t e;
    if (k_m == 0) begin
      mdrop = (outstanding >= 2);
      if (mdrop) exp_drop = 1;
    end
    buf_m[k_m] = re * re + im * im;
    if (k_m == 255 && !mdrop) begin
      for (int b = 0; b <= 128; b++) begin
        e.bin  = 8'(b);
        e.pwr  = 30'(buf_m[bitrev8(b)]);
        e.last = (b == 128);
        exp_q.push_back(e);
      end
      outstanding++;
    end
    k_m = (k_m + 1) % 256;
  endfunction

  // One clock: drive inputs, examine what the DUT shows now, advance.
  task automatic cycle(input logic v, input int re, input int im, input logic rdy);
    exp_t e;
    valid_in  = v;
    Re_in     = re[14:0];
    Im_in     = im[14:0];
    out_ready = rdy;
    if (frame_drop || exp_drop) check("frame_drop", 64'(frame_drop), 64'(exp_drop));
    if (frame_drop === 1'b1) begin
      drop_seen++;
      drop_call = call_no;
    end
    exp_drop = 0;
    if (hold_v) check("stall_hold", 64'({out_valid, out_bin, out_pwr, out_last}), 64'(held));
    hold_v = 0;
    if (out_valid === 1'b1 && prev_valid !== 1'b1) rise_call = call_no;
    prev_valid = out_valid;
    if (rst || !spi_en) begin
      model_clear();
    end else begin
      if (v) accept_model(re, im);
      if (out_valid === 1'b1 && rdy) begin
        xfer_cnt++;
        got_pwr[out_bin] = out_pwr;
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 64'({out_bin, out_pwr}), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("xfer", 64'({out_bin, out_pwr, out_last}), 64'({e.bin, e.pwr, e.last}));
          if (e.last) outstanding--;
        end
      end else if (out_valid === 1'b1) begin
        hold_v = 1;
        held = {out_valid, out_bin, out_pwr, out_last};
      end
    end
    call_no++;
    @(negedge clk);
  endtask

  task automatic feed(input int mode, input int gap_mod, input int count);
    for (int k = 0; k < count; k++) begin
      if (gap_mod != 0 && $urandom_range(0, gap_mod - 1) == 0) cycle(0, 0, 0, get_rdy(mode));
      if (k == 0) k0_call = call_no;
      if (k == 255) last_call = call_no;
      cycle(1, fre[k], fim[k], get_rdy(mode));
    end
  endtask

  task automatic drain(input int mode, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && n < budget) begin
      cycle(0, 0, 0, get_rdy(mode));
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
    repeat (5) cycle(0, 0, 0, 1'b1);
  endtask

  task automatic clear_got();
    for (int b = 0; b <= 128; b++) got_pwr[b] = '1;
  endtask

  vec_t tbl [7];
  int   x0;
  int   d0;
  int   cnt;

  initial begin
    tbl[0] = '{0,   -16384, -16384, 536870912};
    tbl[1] = '{1,    16383,  16383, 536805378};
    tbl[2] = '{64,  -16384,      0, 268435456};
    tbl[3] = '{127,      0,      0, 0};
    tbl[4] = '{128,     -1,      1, 2};
    tbl[5] = '{5,      100,   -200, 50000};
    tbl[6] = '{100,  16383, -16384, 536838145};

    rst = 1'b1; spi_en = 1'b1; valid_in = 1'b0; out_ready = 1'b0;
    Re_in = '0; Im_in = '0;
    @(negedge clk);
    repeat (3) cycle(0, 0, 0, 1'b0);
    rst = 1'b0;
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_out_bin",    64'(out_bin),    64'(0));
    check("rst_out_pwr",    64'(out_pwr),    64'(0));
    check("rst_out_last",   64'(out_last),   64'(0));
    check("rst_frame_drop", 64'(frame_drop), 64'(0));

    // Ramp frame: Re=k, Im=0, ready high; also checks first-output latency.
    for (int k = 0; k < 256; k++) begin fre[k] = k; fim[k] = 0; end
    clear_got(); x0 = xfer_cnt; rise_call = -1;
    feed(1, 0, 256);
    drain(1, 1000);
    check("ramp_count", 64'(xfer_cnt - x0), 64'(129));
    check("ramp_latency", 64'(rise_call - last_call), 64'(4));
    check("ramp_bin128", 64'(got_pwr[128]), 64'(1));
    check("ramp_bin1", 64'(got_pwr[1]), 64'(16384));

    // Table vectors placed at their bit-reversed arrival slots.
    for (int k = 0; k < 256; k++) begin fre[k] = 0; fim[k] = 0; end
    foreach (tbl[i]) begin
      fre[bitrev8(tbl[i].bin)] = tbl[i].re;
      fim[bitrev8(tbl[i].bin)] = tbl[i].im;
    end
    clear_got();
    feed(1, 0, 256);
    drain(1, 1000);
    foreach (tbl[i]) check($sformatf("table_bin%0d", tbl[i].bin), 64'(got_pwr[tbl[i].bin]), 64'(tbl[i].exp_pwr));

    // Most negative inputs everywhere.
    for (int k = 0; k < 256; k++) begin fre[k] = -16384; fim[k] = -16384; end
    clear_got();
    feed(1, 0, 256);
    drain(1, 1000);
    cnt = 0;
    for (int b = 0; b <= 128; b++) if (got_pwr[b] == 30'd536870912) cnt++;
    check("maxneg_all", 64'(cnt), 64'(129));

    // Consumer stalled for three frames: two stored, third dropped.
    x0 = xfer_cnt; d0 = drop_seen;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 256; k++) begin
        fre[k] = int'($urandom_range(0, 32767)) - 16384;
        fim[k] = int'($urandom_range(0, 32767)) - 16384;
      end
      feed(0, 0, 256);
    end
    repeat (3) cycle(0, 0, 0, 1'b0);
    check("stall3_drop_count", 64'(drop_seen - d0), 64'(1));
    check("stall3_drop_time", 64'(drop_call - k0_call), 64'(1));
    drain(1, 1000);
    check("stall3_xfers", 64'(xfer_cnt - x0), 64'(258));

    // out_ready toggling every cycle.
    for (int k = 0; k < 256; k++) begin fre[k] = 255 - k; fim[k] = k - 128; end
    x0 = xfer_cnt;
    feed(2, 0, 256);
    drain(2, 1000);
    check("toggle_xfers", 64'(xfer_cnt - x0), 64'(129));

    // Reset at arrival 100, then a clean frame.
    for (int k = 0; k < 256; k++) begin fre[k] = k + 7; fim[k] = -k; end
    x0 = xfer_cnt;
    feed(1, 0, 100);
    rst = 1'b1; cycle(1, 5, 5, 1'b1); rst = 1'b0;
    feed(1, 0, 256);
    drain(1, 1000);
    check("rst_k100_xfers", 64'(xfer_cnt - x0), 64'(129));

    // Enable low at arrival 100, then a clean frame.
    x0 = xfer_cnt;
    feed(1, 0, 100);
    spi_en = 1'b0; repeat (3) cycle(1, 9, 9, 1'b1); spi_en = 1'b1;
    feed(1, 0, 256);
    drain(1, 1000);
    check("en_k100_xfers", 64'(xfer_cnt - x0), 64'(129));

    // Reset in the middle of a readout.
    feed(1, 0, 256);
    repeat (20) cycle(0, 0, 0, 1'b1);
    rst = 1'b1; cycle(0, 0, 0, 1'b1); rst = 1'b0;
    check("rst_readout_valid", 64'(out_valid), 64'(0));
    check("rst_readout_bin", 64'(out_bin), 64'(0));
    x0 = xfer_cnt;
    feed(1, 0, 256);
    drain(1, 1000);
    check("rst_readout_xfers", 64'(xfer_cnt - x0), 64'(129));

    // Randomized frames with input gaps and random backpressure.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 256; k++) begin
        fre[k] = int'($urandom_range(0, 32767)) - 16384;
        fim[k] = int'($urandom_range(0, 32767)) - 16384;
      end
      feed((f < 4) ? 3 : 4, 8, 256);
    end
    drain(1, 3000);
    check("random_outstanding", 64'(outstanding), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
